// File: rtl/modulador_sequencer.sv
// modulador_sequencer
//   Drives the modulator's 4-bit channel enable. A one-hot enable walks
//   through the channels of a mask latched at start. Each channel is held
//   for DWELL_CYCLES cycles. Consecutive channels are separated by
//   GAP_CYCLES all-zero cycles (break-before-make). The walk repeats for
//   NB_ROUNDS passes; NB_ROUNDS=0 means it runs until stopped.
//
// Ports
//   clock     system clock, rising edge
//   i_reset   asynchronous reset, active low
//   i_start   level; starts a sequence from IDLE when the mask is non-zero
//   i_stop    abort to IDLE, no done pulse
//   i_mask    participating channels, latched on an accepted start
//   o_enable  one-hot channel enable, or zero
//   o_busy    high while the sequence is in RUN or GAP
//   o_done    one-cycle pulse after the last channel of the last round
//   o_step    index of the current or last-driven channel
module modulador_sequencer #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES   = 10,
  parameter int unsigned NB_ROUNDS    = 1
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [3:0] i_mask,
  output logic [3:0] o_enable,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_step
);

  // Counters run from N-1 down to 0, so 0 marks the last cycle of a phase.
  localparam logic [23:0] DWELL_LOAD = 24'(DWELL_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  LAST_ROUND = 8'(NB_ROUNDS - 1);
  localparam logic        COUNTED    = (NB_ROUNDS != 0);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t      state;
  logic [3:0]  mask_q;
  logic [23:0] dwell_cnt;
  logic [15:0] gap_cnt;
  logic [7:0]  round_cnt;

  logic [1:0]  first_step;
  logic [1:0]  next_step;
  logic        wrap;
  logic        last_chan;

  always_comb begin
    // Lowest set bit of the incoming mask. The loop scans downward so the
    // lowest index is the one assigned last.
    first_step = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (i_mask[i]) first_step = 2'(i);

    // Next set bit above the current step, modulo 4. Offsets are scanned
    // downward so the nearest bit wins. If no other bit is set, the channel
    // repeats, which gives the single-bit-mask behaviour.
    next_step = o_step;
    for (int i = 3; i >= 1; i--)
      if (mask_q[o_step + 2'(i)]) next_step = o_step + 2'(i);

    // Landing at or below the current step closes a round.
    wrap      = (next_step <= o_step);
    last_chan = COUNTED && wrap && (round_cnt == LAST_ROUND);
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      mask_q    <= 4'd0;
      dwell_cnt <= 24'd0;
      gap_cnt   <= 16'd0;
      round_cnt <= 8'd0;
      o_enable  <= 4'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_step    <= 2'd0;
    end else begin
      o_done <= 1'b0;
      if (i_stop) begin
        // The step index is kept so the last-driven channel stays visible.
        state    <= IDLE;
        o_enable <= 4'd0;
        o_busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start && (i_mask != 4'd0)) begin
              mask_q    <= i_mask;
              o_step    <= first_step;
              dwell_cnt <= DWELL_LOAD;
              round_cnt <= 8'd0;
              o_enable  <= 4'b0001 << first_step;
              o_busy    <= 1'b1;
              state     <= RUN;
            end
          end
          RUN: begin
            if (dwell_cnt == 24'd0) begin
              o_enable <= 4'd0;
              if (last_chan) begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
                state  <= DONE;
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end
            end else begin
              dwell_cnt <= dwell_cnt - 24'd1;
            end
          end
          GAP: begin
            if (gap_cnt == 16'd0) begin
              o_step    <= next_step;
              dwell_cnt <= DWELL_LOAD;
              o_enable  <= 4'b0001 << next_step;
              if (COUNTED && wrap) round_cnt <= round_cnt + 8'd1;
              state     <= RUN;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
